// File: rtl/snake_renderer_pipe.sv
// Two-stage RGB565 renderer for the snake game: border, food block and up to MAX_LEN
// segments, with a double-buffered segment file swapped at frame start.
module snake_renderer_pipe #(
   parameter int MAX_LEN    = 32,
   parameter int IDX_W      = 5,
   parameter int BLOCK_W    = 20,
   parameter int SIDE_W     = 10,
   parameter int H_DISP     = 640,
   parameter int V_DISP     = 480,
   parameter int FLASH_LOG2 = 4
) (
   input  logic             vga_clk,
   input  logic             sys_rst_n,
   input  logic [9:0]       pixel_xpos,
   input  logic [9:0]       pixel_ypos,
   input  logic             frame_start,
   input  logic             seg_we,
   input  logic [IDX_W-1:0] seg_idx,
   input  logic [9:0]       seg_x,
   input  logic [9:0]       seg_y,
   input  logic [IDX_W:0]   snake_len,
   input  logic [9:0]       food_x,
   input  logic [9:0]       food_y,
   input  logic             food_en,
   input  logic             game_over,
   output logic [15:0]      pixel_data
);

   localparam int LEN_W = IDX_W + 1;
   localparam int AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   localparam logic [15:0] COL_BORDER = 16'h8A22;
   localparam logic [15:0] COL_FOOD   = 16'hFFFF;
   localparam logic [15:0] COL_HEAD   = 16'hF800;
   localparam logic [15:0] COL_ODD    = 16'hFD20;
   localparam logic [15:0] COL_EVEN   = 16'h7FFA;
   localparam logic [15:0] COL_BG     = 16'h0000;

   logic [9:0]            sh_x_q  [MAX_LEN];
   logic [9:0]            sh_y_q  [MAX_LEN];
   logic [9:0]            act_x_q [MAX_LEN];
   logic [9:0]            act_y_q [MAX_LEN];
   logic [LEN_W-1:0]      act_len_q, act_len_d;
   logic [9:0]            food_x_q, food_y_q;
   logic                  food_en_q;
   logic [FLASH_LOG2-1:0] flash_q, flash_d;
   logic                  seg_wr_s;

   logic                  s1_border_q, s1_border_d;
   logic                  s1_food_q, s1_food_d;
   logic [MAX_LEN-1:0]    s1_hit_q, s1_hit_d;
   logic                  s1_blank_q, s1_blank_d;

   logic [15:0]           pix_q, pix_d;
   logic                  body_found_s;
   logic                  body_odd_s;

   // Square hit test; ends computed one bit wider so blocks near 1023 never wrap.
   function automatic logic in_block(input logic [9:0] px, input logic [9:0] py,
                                     input logic [9:0] bx, input logic [9:0] by);
      logic [10:0] x_end;
      logic [10:0] y_end;
      x_end = {1'b0, bx} + 11'(BLOCK_W);
      y_end = {1'b0, by} + 11'(BLOCK_W);
      return (px >= bx) && ({1'b0, px} < x_end) && (py >= by) && ({1'b0, py} < y_end);
   endfunction

   // Out-of-range indices are dropped rather than aliased onto low segments.
   always_comb begin
      seg_wr_s = seg_we && ({1'b0, seg_idx} < LEN_W'(MAX_LEN));
   end

   // Shadow segment file written by the game logic.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            sh_x_q[i] <= 10'd0;
            sh_y_q[i] <= 10'd0;
         end
      end else if (seg_wr_s) begin
         sh_x_q[seg_idx[AW-1:0]] <= seg_x;
         sh_y_q[seg_idx[AW-1:0]] <= seg_y;
      end
   end

   // Length clamp applied at the swap.
   always_comb begin
      if (snake_len > LEN_W'(MAX_LEN)) begin
         act_len_d = LEN_W'(MAX_LEN);
      end else begin
         act_len_d = snake_len;
      end
   end

   // Frame-start swap; a same-cycle write is not seen until the next swap.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i < MAX_LEN; i++) begin
            act_x_q[i] <= 10'd0;
            act_y_q[i] <= 10'd0;
         end
         act_len_q <= '0;
         food_x_q  <= 10'd0;
         food_y_q  <= 10'd0;
         food_en_q <= 1'b0;
      end else if (frame_start) begin
         act_x_q   <= sh_x_q;
         act_y_q   <= sh_y_q;
         act_len_q <= act_len_d;
         food_x_q  <= food_x;
         food_y_q  <= food_y;
         food_en_q <= food_en;
      end
   end

   // Blink counter advances once per frame while the game is over.
   always_comb begin
      if (!game_over) begin
         flash_d = '0;
      end else if (frame_start) begin
         flash_d = flash_q + FLASH_LOG2'(1);
      end else begin
         flash_d = flash_q;
      end
   end

   // Blink counter register.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         flash_q <= '0;
      end else begin
         flash_q <= flash_d;
      end
   end

   // Stage 1 geometry: border, food and per-segment hits masked by the active length.
   always_comb begin
      s1_border_d = (pixel_xpos < 10'(SIDE_W)) || (pixel_xpos >= 10'(H_DISP - SIDE_W)) ||
                    (pixel_ypos < 10'(SIDE_W)) || (pixel_ypos >= 10'(V_DISP - SIDE_W));
      s1_food_d   = food_en_q && in_block(pixel_xpos, pixel_ypos, food_x_q, food_y_q);
      s1_blank_d  = game_over && flash_q[FLASH_LOG2-1];
      s1_hit_d    = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         s1_hit_d[i] = (LEN_W'(i) < act_len_q) &&
                       in_block(pixel_xpos, pixel_ypos, act_x_q[i], act_y_q[i]);
      end
   end

   // Stage 1 registers.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s1_border_q <= 1'b0;
         s1_food_q   <= 1'b0;
         s1_hit_q    <= '0;
         s1_blank_q  <= 1'b0;
      end else begin
         s1_border_q <= s1_border_d;
         s1_food_q   <= s1_food_d;
         s1_hit_q    <= s1_hit_d;
         s1_blank_q  <= s1_blank_d;
      end
   end

   // Stage 2: lowest-index body hit (descending scan so the smallest index wins) and colour mux.
   always_comb begin
      body_found_s = |s1_hit_q[MAX_LEN-1:1];
      body_odd_s   = 1'b0;
      for (int i = MAX_LEN - 1; i >= 1; i--) begin
         body_odd_s = s1_hit_q[i] ? i[0] : body_odd_s;
      end
      if (s1_border_q) begin
         pix_d = COL_BORDER;
      end else if (s1_food_q) begin
         pix_d = COL_FOOD;
      end else if (s1_blank_q) begin
         pix_d = COL_BG;
      end else if (s1_hit_q[0]) begin
         pix_d = COL_HEAD;
      end else if (body_found_s) begin
         pix_d = body_odd_s ? COL_ODD : COL_EVEN;
      end else begin
         pix_d = COL_BG;
      end
   end

   // Stage 2 output register.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pix_q <= 16'h0000;
      end else begin
         pix_q <= pix_d;
      end
   end

   assign pixel_data = pix_q;

endmodule

// File: tb/tb_snake_renderer_pipe.sv
// Directed bench for snake_renderer_pipe: render, double buffering, priority, clamp,
// blinking and asynchronous reset, all against hand-computed colours.
module tb_snake_renderer_pipe;

   localparam int IDX_W = 6;

   logic             vga_clk;
   logic             sys_rst_n;
   logic [9:0]       pixel_xpos;
   logic [9:0]       pixel_ypos;
   logic             frame_start;
   logic             seg_we;
   logic [IDX_W-1:0] seg_idx;
   logic [9:0]       seg_x;
   logic [9:0]       seg_y;
   logic [IDX_W:0]   snake_len;
   logic [9:0]       food_x;
   logic [9:0]       food_y;
   logic             food_en;
   logic             game_over;
   logic [15:0]      pixel_data;

   int total = 0;
   int bad   = 0;

   snake_renderer_pipe #(.IDX_W(IDX_W)) dut (
      .vga_clk     (vga_clk),
      .sys_rst_n   (sys_rst_n),
      .pixel_xpos  (pixel_xpos),
      .pixel_ypos  (pixel_ypos),
      .frame_start (frame_start),
      .seg_we      (seg_we),
      .seg_idx     (seg_idx),
      .seg_x       (seg_x),
      .seg_y       (seg_y),
      .snake_len   (snake_len),
      .food_x      (food_x),
      .food_y      (food_y),
      .food_en     (food_en),
      .game_over   (game_over),
      .pixel_data  (pixel_data)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic wr_seg(input logic [IDX_W-1:0] idx, input logic [9:0] x, input logic [9:0] y);
      @(negedge vga_clk);
      seg_we = 1'b1; seg_idx = idx; seg_x = x; seg_y = y;
      @(negedge vga_clk);
      seg_we = 1'b0;
   endtask

   task automatic fs(input logic [IDX_W:0] len, input logic [9:0] fx, input logic [9:0] fy,
                     input logic fen);
      @(negedge vga_clk);
      snake_len = len; food_x = fx; food_y = fy; food_en = fen; frame_start = 1'b1;
      @(negedge vga_clk);
      frame_start = 1'b0;
      @(negedge vga_clk);
   endtask

   task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                        input logic [15:0] exp);
      @(negedge vga_clk);
      pixel_xpos = x; pixel_ypos = y;
      @(negedge vga_clk);
      @(negedge vga_clk);
      chk(tag, pixel_data, exp);
   endtask

   int          sx [6] = '{105, 125, 145, 305, 5, 400};
   int          sy [6] = '{105, 105, 105, 205, 5, 400};
   logic [15:0] se [6] = '{16'hF800, 16'hFD20, 16'h7FFA, 16'hFFFF, 16'h8A22, 16'h0000};

   initial begin
      sys_rst_n = 1'b0; pixel_xpos = 10'd0; pixel_ypos = 10'd0; frame_start = 1'b0;
      seg_we = 1'b0; seg_idx = '0; seg_x = 10'd0; seg_y = 10'd0; snake_len = '0;
      food_x = 10'd0; food_y = 10'd0; food_en = 1'b0; game_over = 1'b0;
      repeat (3) @(negedge vga_clk);
      chk("reset_pix", pixel_data, 16'h0000);
      sys_rst_n = 1'b1;

      // basic render, with a streaming scan to pin the 2-cycle latency
      wr_seg(6'd0, 10'd100, 10'd100);
      wr_seg(6'd1, 10'd120, 10'd100);
      wr_seg(6'd2, 10'd140, 10'd100);
      probe("pre_swap", 10'd105, 10'd105, 16'h0000);
      fs(7'd3, 10'd300, 10'd200, 1'b1);
      for (int k = 0; k < 8; k++) begin
         @(negedge vga_clk);
         if (k >= 2) chk($sformatf("stream%0d", k - 2), pixel_data, se[k-2]);
         if (k < 6) begin
            pixel_xpos = 10'(sx[k]); pixel_ypos = 10'(sy[k]);
         end else begin
            pixel_xpos = 10'd400; pixel_ypos = 10'd400;
         end
      end

      // double buffering
      wr_seg(6'd0, 10'd200, 10'd200);
      probe("dbuf_old", 10'd105, 10'd105, 16'hF800);
      probe("dbuf_new_hidden", 10'd205, 10'd205, 16'h0000);
      fs(7'd3, 10'd300, 10'd200, 1'b1);
      probe("dbuf_new_shown", 10'd205, 10'd205, 16'hF800);
      probe("dbuf_old_gone", 10'd105, 10'd105, 16'h0000);

      // write coinciding with frame_start
      @(negedge vga_clk);
      seg_we = 1'b1; seg_idx = 6'd0; seg_x = 10'd50; seg_y = 10'd50;
      snake_len = 7'd3; frame_start = 1'b1;
      @(negedge vga_clk);
      seg_we = 1'b0; frame_start = 1'b0;
      probe("simul_hidden", 10'd55, 10'd55, 16'h0000);
      probe("simul_oldhead", 10'd205, 10'd205, 16'hF800);
      fs(7'd3, 10'd300, 10'd200, 1'b1);
      probe("simul_shown", 10'd55, 10'd55, 16'hF800);

      // overlap and priority
      wr_seg(6'd0, 10'd100, 10'd100);
      wr_seg(6'd1, 10'd160, 10'd160);
      wr_seg(6'd2, 10'd160, 10'd160);
      wr_seg(6'd3, 10'd0, 10'd0);
      fs(7'd4, 10'd100, 10'd100, 1'b1);
      probe("food_over_head", 10'd105, 10'd105, 16'hFFFF);
      probe("low_idx_wins", 10'd165, 10'd165, 16'hFD20);
      probe("border_over_seg", 10'd5, 10'd5, 16'h8A22);
      probe("seg_inside_edge", 10'd12, 10'd12, 16'hFD20);

      // clamp and out-of-range write (index 40 would alias seg 8 if not dropped)
      wr_seg(6'd31, 10'd400, 10'd300);
      wr_seg(6'd40, 10'd300, 10'd300);
      fs(7'd63, 10'd100, 10'd100, 1'b1);
      probe("clamp_seg31", 10'd405, 10'd305, 16'hFD20);
      probe("idx40_dropped", 10'd305, 10'd305, 16'h0000);
      fs(7'd31, 10'd100, 10'd100, 1'b1);
      probe("len31_masks31", 10'd405, 10'd305, 16'h0000);

      // blinking
      game_over = 1'b1;
      repeat (7) fs(7'd4, 10'd300, 10'd200, 1'b1);
      probe("blink7_head", 10'd105, 10'd105, 16'hF800);
      fs(7'd4, 10'd300, 10'd200, 1'b1);
      probe("blink8_head", 10'd105, 10'd105, 16'h0000);
      probe("blink8_food", 10'd305, 10'd205, 16'hFFFF);
      probe("blink8_border", 10'd5, 10'd5, 16'h8A22);
      repeat (8) fs(7'd4, 10'd300, 10'd200, 1'b1);
      probe("blink16_head", 10'd105, 10'd105, 16'hF800);
      repeat (8) fs(7'd4, 10'd300, 10'd200, 1'b1);
      probe("blink24_head", 10'd105, 10'd105, 16'h0000);
      game_over = 1'b0;
      probe("go_low_head", 10'd105, 10'd105, 16'hF800);
      game_over = 1'b1;
      probe("cnt_cleared_head", 10'd105, 10'd105, 16'hF800);
      game_over = 1'b0;

      // asynchronous reset mid-line
      @(posedge vga_clk);
      #2 sys_rst_n = 1'b0;
      #1 chk("rst_async", pixel_data, 16'h0000);
      @(negedge vga_clk);
      sys_rst_n = 1'b1;
      probe("post_rst_head", 10'd105, 10'd105, 16'h0000);
      probe("post_rst_food", 10'd305, 10'd205, 16'h0000);
      fs(7'd3, 10'd300, 10'd200, 1'b0);
      probe("shadow_cleared", 10'd12, 10'd12, 16'hF800);
      probe("old_head_gone", 10'd105, 10'd105, 16'h0000);
      probe("food_disabled", 10'd305, 10'd205, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/snake_renderer_pipe.md
# snake_renderer_pipe

Parametrised, pipelined RGB565 pixel renderer for the snake game. It draws a border, one food block and a snake of up to MAX_LEN segments. Segment coordinates are held in an internal double-buffered register file, loaded through a write port and swapped atomically at frame start so the picture never tears. It sits between the game-logic FSM and the VGA timing generator, and adds game-over flashing and alternating body colours.

## Interface
- MAX_LEN, 32: maximum number of segments drawn.
- IDX_W, 5: segment index width; 2^IDX_W >= MAX_LEN.
- BLOCK_W, 20: segment and food square edge, in pixels.
- SIDE_W, 10: border width, in pixels.
- H_DISP, 640: active width.
- V_DISP, 480: active height.
- FLASH_LOG2, 4: game-over blink half-period is 2^(FLASH_LOG2-1) frames.

- vga_clk  in  1: pixel clock.
- sys_rst_n  in  1: reset, asynchronous, active-low.
- pixel_xpos  in  10: current scan x.
- pixel_ypos  in  10: current scan y.
- frame_start  in  1: one-cycle pulse at start of vertical blanking.
- seg_we  in  1: segment write strobe.
- seg_idx  in  IDX_W: segment index to write (0 = head).
- seg_x  in  10: segment x write data.
- seg_y  in  10: segment y write data.
- snake_len  in  IDX_W+1: requested segment count, sampled at frame_start.
- food_x  in  10: food x, sampled at frame_start.
- food_y  in  10: food y, sampled at frame_start.
- food_en  in  1: food visible, sampled at frame_start.
- game_over  in  1: enables snake blinking.
- pixel_data  out  16: RGB565 colour for the position presented 2 cycles earlier.

## Operation
- **Write port.** seg_we=1 writes seg_x and seg_y into shadow[seg_idx]. Writes with seg_idx >= MAX_LEN are ignored.
- **Frame swap.** On frame_start the block performs these copies in one cycle:
  - shadow array into active array;
  - snake_len into act_len, clamped to MAX_LEN;
  - food_x, food_y and food_en into active food registers.
- **Write coinciding with frame_start.** The copy uses the shadow contents from before the write. The write still lands in shadow and becomes visible at the next frame_start.
- **Hit test.** seg i hits when x >= ax[i], x < ax[i]+BLOCK_W, y >= ay[i] and y < ay[i]+BLOCK_W. Sums are computed 11 bits wide, so there is no wrap. Only segments with i < act_len are tested. act_len=0 means no snake is drawn.
- **Border.** Border when x < SIDE_W, x >= H_DISP-SIDE_W, y < SIDE_W or y >= V_DISP-SIDE_W.
- **Colour priority,** highest first:
  - border: 16'h8A22;
  - food, if food_en: 16'hFFFF;
  - head (seg 0): 16'hF800;
  - lowest-index body seg i: 16'hFD20 if i odd, 16'h7FFA if i even;
  - background: 16'h0000.
- **Blinking.** flash_cnt (FLASH_LOG2 bits) increments on each frame_start while game_over=1. It is cleared to 0 whenever game_over=0.
  - While game_over=1 and flash_cnt MSB=1, snake hits are suppressed and show background.
  - Border and food are unaffected.
- **Reset.** Reset clears all of the following to 0: shadow and active arrays, act_len, food registers, flash_cnt, pipeline registers, and pixel_data. Reset asserted mid-frame takes effect immediately (asynchronous). Output stays black until the next frame_start after release, because act_len=0 and food_en=0.

## Timing
- **Stage 1 (register).** Border flag, food flag, the MAX_LEN-bit hit vector (masked by act_len), and the blink-suppress flag.
- **Stage 2 (register).** Priority encode of the hit vector plus colour mux into pixel_data.
- **Latency.** Exactly 2 vga_clk cycles from the pixel_xpos/pixel_ypos sample to the matching pixel_data. The timing generator delays sync by 2 to compensate.
- **Throughput.** One pixel per cycle, no stalls.
- **When new state takes effect.** act_len, the active arrays and food are used starting with the pixel sampled in the cycle after frame_start.
- **Blink edges.** A flash_cnt change affects pixels sampled from the cycle after frame_start.
- **Input stability.** pixel_xpos and pixel_ypos may change every cycle. frame_start must not repeat within 2 cycles.

## Test plan
- **Basic render.** Reset, write seg0=(100,100), seg1=(120,100), seg2=(140,100), snake_len=3, food=(300,200) with food_en=1, pulse frame_start.
  - Scan (105,105) -> F800; (125,105) -> FD20; (145,105) -> 7FFA; (305,205) -> FFFF; (5,5) -> 8A22; (400,400) -> 0000.
  - Each colour appears exactly 2 cycles after its coordinate.
- **Double buffering.** After the basic render, write seg0=(200,200) without frame_start.
  - (105,105) is still F800 and (205,205) is 0000.
  - After frame_start, (205,205) -> F800.
- **Simultaneous write and swap.** seg_we for seg0=(50,50) in the same cycle as frame_start.
  - (55,55) -> 0000 this frame and F800 after the next frame_start.
- **Overlap and priority.** Food=(100,100) on top of the head -> FFFF. seg1=seg2=(160,160) -> FD20 (lower index wins). Segment at (0,0) -> 8A22 inside the border.
- **Clamp and bounds.** snake_len=63 with MAX_LEN=32 -> 32 segments drawn. A write to seg_idx=40 (IDX_W=6) leaves the arrays unchanged.
- **Blink and reset.** game_over=1 with FLASH_LOG2=4.
  - After 8 frame_starts the head pixel reads 0000 while the food is still FFFF. After 16 it reads F800 again.
  - sys_rst_n pulsed low mid-line -> pixel_data=0000 immediately, and stays 0000 after release until the scene is reloaded.
